// File: rtl/dma_pkg.sv
// dma_pkg
// Shared definitions for the DMA bus engine and the CI controller that programs it:
// the bus-engine FSM state encoding, bus constants and the CI register indices.
// No ports; imported with "import dma_pkg::*".

package dma_pkg;

    // Width of the bus burst-size field (beats minus one).
    localparam int BURST_W = 8;

    // Byte enables driven in every begin cycle; the engine only moves whole words.
    localparam logic [3:0] BUS_BYTE_EN_ALL = 4'hF;

    // Register indices decoded by the DMA control custom instruction.
    localparam logic [2:0] CI_REG_BUS_ADDR   = 3'd0;
    localparam logic [2:0] CI_REG_MEM_ADDR   = 3'd1;
    localparam logic [2:0] CI_REG_BLOCK_SIZE = 3'd2;
    localparam logic [2:0] CI_REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] CI_REG_STATUS     = 3'd4;
    localparam logic [2:0] CI_REG_CONTROL    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BEGIN = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4,
        ST_WEND  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dma_burst_counter.sv
// dma_burst_counter
// Tracks how many words of the current block are still to be moved and sizes the
// next burst as min(burst_size + 1, remaining).
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   load           latch load_size as the new remaining count
//   load_size      total words of the block
//   burst_size     programmed beats-minus-one of every burst
//   consume        subtract the current burst's beats from the remaining count
//   beats          beats of the current burst
//   last_burst     the current burst finishes the block
// BLOCK_W must be wider than BURST_W so that burst_size + 1 cannot overflow.

module dma_burst_counter
    import dma_pkg::*;
#(
    parameter int BLOCK_W = 10
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_size,
    input  logic [BURST_W-1:0] burst_size,
    input  logic               consume,
    output logic [BLOCK_W-1:0] beats,
    output logic               last_burst
);

    logic [BLOCK_W-1:0] remaining_q;
    logic [BLOCK_W-1:0] remaining_d;
    logic [BLOCK_W-1:0] burst_beats;

    always_comb begin
        burst_beats = BLOCK_W'(burst_size) + BLOCK_W'(1);
        beats       = (burst_beats < remaining_q) ? burst_beats : remaining_q;
        remaining_d = remaining_q;
        if (load) begin
            remaining_d = load_size;
        end else if (consume) begin
            remaining_d = remaining_q - beats;
        end
    end

    assign last_burst = (remaining_q == beats);

    always_ff @(posedge clock) begin
        if (reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: rtl/dma_bus_engine.sv
// dma_bus_engine
// Bus-side transfer engine started by the DMA control custom instruction. It copies
// a block of words between the shared system bus and the local dual-port DMA memory
// as a series of bursts, and reports busy / sticky error back to the CI.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   start_read / start_write     1-cycle start pulses (read wins if both)
//   bus_start_address, mem_start_address, block_size, burst_size
//                                transfer registers, latched on an accepted start
//   engine_busy, engine_error    status back to the CI
//   mem_*                        local memory port (1-cycle synchronous read)
//   bus_request / bus_granted    arbitration
//   begin_transaction .. end_transaction_out
//                                master-driven bus signals, 0 whenever not driving
//   address_data_in .. error_in  slave-driven bus signals

module dma_bus_engine
    import dma_pkg::*;
#(
    parameter int MEM_ADDR_W = 9,
    parameter int BLOCK_W    = 10
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_read,
    input  logic                  start_write,
    input  logic [31:0]           bus_start_address,
    input  logic [MEM_ADDR_W-1:0] mem_start_address,
    input  logic [BLOCK_W-1:0]    block_size,
    input  logic [BURST_W-1:0]    burst_size,
    output logic                  engine_busy,
    output logic                  engine_error,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data,
    output logic                  bus_request,
    input  logic                  bus_granted,
    output logic                  begin_transaction,
    output logic [31:0]           address_data_out,
    output logic                  read_n_write,
    output logic [BURST_W-1:0]    burst_size_out,
    output logic [3:0]            byte_enables,
    output logic                  data_valid_out,
    output logic                  end_transaction_out,
    input  logic [31:0]           address_data_in,
    input  logic                  data_valid_in,
    input  logic                  busy_in,
    input  logic                  end_transaction_in,
    input  logic                  error_in
);

    dma_state_e            state_q, state_d;
    logic [31:0]           bus_addr_q, bus_addr_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [BLOCK_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                  dir_read_q, dir_read_d;
    logic                  error_q, error_d;

    logic                  accept_start;
    logic                  consume_burst;
    logic                  last_burst;
    logic                  write_beat_taken;
    logic [BLOCK_W-1:0]    beats;

    assign accept_start     = (state_q == ST_IDLE) && (start_read || start_write)
                              && (block_size != '0);
    assign consume_burst    = (state_q == ST_WEND);
    assign write_beat_taken = (state_q == ST_WDATA) && !busy_in;

    dma_burst_counter #(
        .BLOCK_W    (BLOCK_W)
    ) u_burst_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (accept_start),
        .load_size  (block_size),
        .burst_size (burst_q),
        .consume    (consume_burst),
        .beats      (beats),
        .last_burst (last_burst)
    );

    // Next-state logic. In write mode mem_addr_q always names the word currently
    // presented on the bus; it only advances when the slave takes the beat.
    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        mem_addr_d = mem_addr_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        dir_read_d = dir_read_q;
        error_d    = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_start) begin
                    state_d    = ST_REQ;
                    bus_addr_d = bus_start_address & 32'hFFFF_FFFC;
                    mem_addr_d = mem_start_address;
                    burst_d    = burst_size;
                    dir_read_d = start_read;
                    error_d    = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus_granted) begin
                    state_d = ST_BEGIN;
                end
            end
            ST_BEGIN: begin
                beat_cnt_d = '0;
                state_d    = dir_read_q ? ST_RDATA : ST_WDATA;
            end
            ST_RDATA: begin
                if (data_valid_in) begin
                    mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
                end
                if (end_transaction_in) begin
                    state_d = ST_WEND;
                end
            end
            ST_WDATA: begin
                if (write_beat_taken) begin
                    mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + BLOCK_W'(1);
                    if (beat_cnt_q == beats - BLOCK_W'(1)) begin
                        state_d = ST_WEND;
                    end
                end
            end
            ST_WEND: begin
                bus_addr_d = bus_addr_q + (32'(beats) << 2);
                state_d    = last_burst ? ST_IDLE : ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bus error abandons the transfer from any active state.
        if ((state_q != ST_IDLE) && error_in) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bus_addr_q <= '0;
            mem_addr_q <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            dir_read_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            mem_addr_q <= mem_addr_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            dir_read_q <= dir_read_d;
            error_q    <= error_d;
        end
    end

    // Output decode from the registered state. Bus outputs stay 0 outside the states
    // that own them so the engine can sit on a wired-OR bus.
    always_comb begin
        engine_busy         = (state_q != ST_IDLE);
        engine_error        = error_q;
        mem_address         = mem_addr_q;
        mem_write_enable    = 1'b0;
        mem_write_data      = '0;
        bus_request         = 1'b0;
        begin_transaction   = 1'b0;
        address_data_out    = '0;
        read_n_write        = 1'b0;
        burst_size_out      = '0;
        byte_enables        = '0;
        data_valid_out      = 1'b0;
        end_transaction_out = 1'b0;

        unique case (state_q)
            ST_REQ: begin
                bus_request = 1'b1;
            end
            ST_BEGIN: begin
                begin_transaction = 1'b1;
                address_data_out  = bus_addr_q;
                read_n_write      = dir_read_q;
                burst_size_out    = BURST_W'(beats - BLOCK_W'(1));
                byte_enables      = BUS_BYTE_EN_ALL;
            end
            ST_RDATA: begin
                mem_write_enable = data_valid_in;
                mem_write_data   = data_valid_in ? address_data_in : 32'h0;
            end
            ST_WDATA: begin
                // Prefetch: fetch the next word only once the current one is taken,
                // otherwise re-read the same word so the bus data stays put.
                data_valid_out   = 1'b1;
                address_data_out = mem_read_data;
                mem_address      = write_beat_taken ? (mem_addr_q + MEM_ADDR_W'(1))
                                                    : mem_addr_q;
            end
            ST_WEND: begin
                end_transaction_out = !dir_read_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_engine.sv
// tb_dma_bus_engine
// Randomized self-checking bench for dma_bus_engine. Models the local memory, an
// arbiter and a bus slave; expected burst addresses/sizes and transferred words are
// derived from the transfer parameters with plain arithmetic and queues.

module tb_dma_bus_engine;

    localparam int MEM_ADDR_W = 9;
    localparam int BLOCK_W    = 10;
    localparam int MEM_WORDS  = 512;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start_read;
    logic                  start_write;
    logic [31:0]           bus_start_address;
    logic [MEM_ADDR_W-1:0] mem_start_address;
    logic [BLOCK_W-1:0]    block_size;
    logic [7:0]            burst_size;
    logic                  engine_busy;
    logic                  engine_error;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic                  mem_write_enable;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;
    logic                  bus_request;
    logic                  bus_granted;
    logic                  begin_transaction;
    logic [31:0]           address_data_out;
    logic                  read_n_write;
    logic [7:0]            burst_size_out;
    logic [3:0]            byte_enables;
    logic                  data_valid_out;
    logic                  end_transaction_out;
    logic [31:0]           address_data_in;
    logic                  data_valid_in;
    logic                  busy_in;
    logic                  end_transaction_in;
    logic                  error_in;

    logic                  fill_mem;
    logic [31:0]           local_mem [0:MEM_WORDS-1];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    always #5 clock = ~clock;

    dma_bus_engine #(
        .MEM_ADDR_W (MEM_ADDR_W),
        .BLOCK_W    (BLOCK_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start_read          (start_read),
        .start_write         (start_write),
        .bus_start_address   (bus_start_address),
        .mem_start_address   (mem_start_address),
        .block_size          (block_size),
        .burst_size          (burst_size),
        .engine_busy         (engine_busy),
        .engine_error        (engine_error),
        .mem_address         (mem_address),
        .mem_write_enable    (mem_write_enable),
        .mem_write_data      (mem_write_data),
        .mem_read_data       (mem_read_data),
        .bus_request         (bus_request),
        .bus_granted         (bus_granted),
        .begin_transaction   (begin_transaction),
        .address_data_out    (address_data_out),
        .read_n_write        (read_n_write),
        .burst_size_out      (burst_size_out),
        .byte_enables        (byte_enables),
        .data_valid_out      (data_valid_out),
        .end_transaction_out (end_transaction_out),
        .address_data_in     (address_data_in),
        .data_valid_in       (data_valid_in),
        .busy_in             (busy_in),
        .end_transaction_in  (end_transaction_in),
        .error_in            (error_in)
    );

    // Local dual-port memory as seen from the engine: synchronous read, one cycle.
    always @(posedge clock) begin
        if (fill_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                local_mem[i] <= $urandom;
            end
        end else if (mem_write_enable) begin
            local_mem[mem_address] <= mem_write_data;
        end
        mem_read_data <= local_mem[mem_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] ba,
                                 input logic [8:0] ma, input logic [9:0] bs,
                                 input logic [7:0] bu);
        start_read        = rd;
        start_write       = wr;
        bus_start_address = ba;
        mem_start_address = ma;
        block_size        = bs;
        burst_size        = bu;
        step();
        start_read  = 1'b0;
        start_write = 1'b0;
    endtask

    // Runs one whole transfer against the slave/arbiter model and checks it.
    // stall_at: global write beat index where busy_in is held for 3 cycles (-1 none).
    // err_beat: global read beat index replaced by error_in (-1 none).
    task automatic runTransfer(input bit is_read, input bit both, input logic [31:0] baddr,
                               input int maddr, input int size, input int burst,
                               input int stall_pct, input int stall_at, input int err_beat,
                               input bit poke_busy, output bit aborted);
        logic [31:0] exp_words[$];
        logic [31:0] seen[$];
        logic [31:0] cur_addr;
        logic [31:0] sentinel;
        logic [31:0] held;
        logic [31:0] data;
        int          remaining, beats, beat_idx, cnt, guard, stall_left, waited;
        bit          end_sent, bsy, poke;

        aborted    = 1'b0;
        poke       = poke_busy;
        beat_idx   = 0;
        stall_left = 3;
        held       = '0;
        if (!is_read) begin
            for (int i = 0; i < size; i++) exp_words.push_back(local_mem[(maddr + i) % MEM_WORDS]);
        end
        sentinel = local_mem[(maddr + size) % MEM_WORDS];
        cur_addr = baddr & 32'hFFFF_FFFC;

        applyStimulus(is_read || both, !is_read || both, baddr | 32'($urandom_range(0, 3)),
                      9'(maddr), 10'(size), 8'(burst));
        checkOutput("busy_after_start", engine_busy, 1);
        checkOutput("error_clear_on_start", engine_error, 0);

        remaining = size;
        while (remaining > 0 && !aborted) begin
            beats  = (burst + 1 < remaining) ? burst + 1 : remaining;
            waited = 0;
            while (!bus_request && waited < 20) begin
                step();
                waited++;
            end
            if (!bus_request) begin
                checkOutput("request_timeout", 0, 1);
                aborted = 1'b1;
                break;
            end
            if (poke) begin
                poke = 1'b0;
                applyStimulus(1'b1, 1'b0, 32'hDEAD_0000, 9'd100, 10'd7, 8'd0);
                checkOutput("start_while_busy_ignored", bus_request, 1);
            end
            repeat ($urandom_range(0, 2)) step();
            bus_granted = 1'b1;
            step();
            bus_granted = 1'b0;
            checkOutput("begin_strobe", begin_transaction, 1);
            checkOutput("begin_address", address_data_out, cur_addr);
            checkOutput("begin_rnw", read_n_write, is_read);
            checkOutput("begin_burst_size", burst_size_out, beats - 1);
            checkOutput("begin_byte_en", byte_enables, 4'hF);
            checkOutput("begin_drops_request", bus_request, 0);
            step();

            if (is_read) begin
                end_sent = 1'b0;
                for (int b = 0; b < beats && !aborted; b++) begin
                    repeat ($urandom_range(0, (stall_pct > 0) ? 2 : 0)) step();
                    if (beat_idx == err_beat) begin
                        error_in = 1'b1;
                        step();
                        error_in = 1'b0;
                        checkOutput("err_bus_request", bus_request, 0);
                        checkOutput("err_begin", begin_transaction, 0);
                        checkOutput("err_addr_data", address_data_out, 0);
                        checkOutput("err_burst_out", burst_size_out, 0);
                        checkOutput("err_flag_set", engine_error, 1);
                        checkOutput("err_busy_low", engine_busy, 0);
                        checkOutput("err_no_mem_write", mem_write_enable, 0);
                        aborted = 1'b1;
                    end else begin
                        data = $urandom;
                        exp_words.push_back(data);
                        address_data_in = data;
                        data_valid_in   = 1'b1;
                        if (b == beats - 1 && $urandom_range(0, 1) == 1) begin
                            end_transaction_in = 1'b1;
                            end_sent           = 1'b1;
                        end
                        step();
                        data_valid_in      = 1'b0;
                        end_transaction_in = 1'b0;
                        address_data_in    = '0;
                        beat_idx++;
                    end
                end
                if (aborted) break;
                if (!end_sent) begin
                    end_transaction_in = 1'b1;
                    step();
                    end_transaction_in = 1'b0;
                end
            end else begin
                cnt   = 0;
                guard = 0;
                while (cnt < beats && guard < 400) begin
                    bsy = ($urandom_range(0, 99) < stall_pct);
                    if (beat_idx == stall_at && stall_left > 0) begin
                        bsy = 1'b1;
                        if (stall_left == 3) held = address_data_out;
                        else checkOutput("stall_data_held", address_data_out, held);
                        stall_left--;
                    end
                    if (!bsy) begin
                        checkOutput("write_beat_valid", data_valid_out, 1);
                        seen.push_back(address_data_out);
                        cnt++;
                        beat_idx++;
                    end
                    busy_in = bsy;
                    step();
                    guard++;
                end
                busy_in = 1'b0;
                if (cnt < beats) begin
                    checkOutput("write_burst_timeout", cnt, beats);
                    aborted = 1'b1;
                    break;
                end
                checkOutput("write_end_txn", end_transaction_out, 1);
                checkOutput("write_valid_drops", data_valid_out, 0);
            end
            checkOutput("busy_through_wend", engine_busy, 1);
            cur_addr  = cur_addr + 32'(4 * beats);
            remaining = remaining - beats;
            step();
        end

        if (!aborted) begin
            checkOutput("busy_drops_after_wend", engine_busy, 0);
            checkOutput("idle_no_request", bus_request, 0);
            if (is_read) begin
                for (int i = 0; i < size; i++)
                    checkOutput("read_word", local_mem[(maddr + i) % MEM_WORDS], exp_words[i]);
                checkOutput("read_no_overrun", local_mem[(maddr + size) % MEM_WORDS], sentinel);
            end else begin
                checkOutput("write_beat_count", seen.size(), size);
                for (int i = 0; i < size && i < seen.size(); i++)
                    checkOutput("write_word", seen[i], exp_words[i]);
            end
        end else if (is_read) begin
            for (int i = 0; i < exp_words.size(); i++)
                checkOutput("kept_after_error", local_mem[(maddr + i) % MEM_WORDS], exp_words[i]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ab;
        int waited;
        reset              = 1'b1;
        fill_mem           = 1'b1;
        start_read         = 1'b0;
        start_write        = 1'b0;
        bus_start_address  = '0;
        mem_start_address  = '0;
        block_size         = '0;
        burst_size         = '0;
        bus_granted        = 1'b0;
        address_data_in    = '0;
        data_valid_in      = 1'b0;
        busy_in            = 1'b0;
        end_transaction_in = 1'b0;
        error_in           = 1'b0;
        step();
        fill_mem = 1'b0;
        step();

        $display("[TB] reset state");
        checkOutput("rst_busy", engine_busy, 0);
        checkOutput("rst_error", engine_error, 0);
        checkOutput("rst_request", bus_request, 0);
        checkOutput("rst_begin", begin_transaction, 0);
        checkOutput("rst_addr_data", address_data_out, 0);
        checkOutput("rst_byte_en", byte_enables, 0);
        checkOutput("rst_dv_out", data_valid_out, 0);
        checkOutput("rst_end_out", end_transaction_out, 0);
        checkOutput("rst_mem_we", mem_write_enable, 0);
        checkOutput("rst_mem_addr", mem_address, 0);
        reset = 1'b0;
        step();

        $display("[TB] single 4-beat read");
        runTransfer(1'b1, 1'b0, 32'h1000, 0, 4, 3, 0, -1, -1, 1'b0, ab);

        $display("[TB] 10-word write in bursts of 4");
        runTransfer(1'b0, 1'b0, 32'h1000, 0, 10, 3, 0, -1, -1, 1'b0, ab);

        $display("[TB] write with slave stall mid-burst");
        runTransfer(1'b0, 1'b0, 32'h2000, 16, 8, 7, 0, 3, -1, 1'b0, ab);

        $display("[TB] bus error on read beat 2");
        runTransfer(1'b1, 1'b0, 32'h3000, 64, 8, 7, 0, -1, 2, 1'b0, ab);
        checkOutput("error_aborts_transfer", ab, 1);
        repeat (3) step();
        checkOutput("error_sticky", engine_error, 1);

        $display("[TB] local address wrap and start while busy");
        runTransfer(1'b1, 1'b0, 32'h4000, 510, 4, 1, 0, -1, -1, 1'b1, ab);

        $display("[TB] bus address wrap");
        runTransfer(1'b0, 1'b0, 32'hFFFF_FFF0, 300, 8, 3, 10, -1, -1, 1'b0, ab);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 1'b1, 32'h5000, 9'd200, 10'd16, 8'd7);
        waited = 0;
        while (!bus_request && waited < 20) begin
            step();
            waited++;
        end
        checkOutput("mid_reset_request", bus_request, 1);
        bus_granted = 1'b1;
        step();
        bus_granted = 1'b0;
        step();
        step();
        checkOutput("mid_reset_in_burst", data_valid_out, 1);
        reset = 1'b1;
        step();
        checkOutput("mid_reset_busy", engine_busy, 0);
        checkOutput("mid_reset_dv_out", data_valid_out, 0);
        checkOutput("mid_reset_addr_data", address_data_out, 0);
        checkOutput("mid_reset_end_out", end_transaction_out, 0);
        checkOutput("mid_reset_request_low", bus_request, 0);
        checkOutput("mid_reset_mem_addr", mem_address, 0);
        reset = 1'b0;
        step();
        checkOutput("no_end_after_reset", end_transaction_out, 0);

        $display("[TB] zero block size start");
        applyStimulus(1'b1, 1'b0, 32'h6000, 9'd0, 10'd0, 8'd3);
        checkOutput("zero_block_busy", engine_busy, 0);
        step();
        checkOutput("zero_block_request", bus_request, 0);
        checkOutput("zero_block_busy_later", engine_busy, 0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 10; t++) begin
            bit rd;
            bit both;
            rd   = 1'($urandom_range(0, 1));
            both = rd && ($urandom_range(0, 3) == 0);
            runTransfer(rd, both, $urandom, $urandom_range(0, MEM_WORDS - 1),
                        $urandom_range(1, 40), $urandom_range(0, 15),
                        $urandom_range(0, 40), -1, -1, 1'b0, ab);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
